uart_tx_frame_serializer: RTL and testbench
===========================================

// Module: uart_tx_frame_serializer
// PURPOSE
//   Serializes one parallel byte into a standard UART frame: start bit, DATA_WIDTH data bits LSB first,
//   optional parity bit, then one stop bit. Transmit-side counterpart of the UART RX data path.
//   Uses the same oversampling clock as RX. Each bit lasts "prescale" clock cycles.
//   Accepts one word per frame. There is no internal FIFO; the upstream side must hold data_valid
//   until busy is low.
// PARAMETERS
//   DATA_WIDTH   8   number of payload bits per frame
// PORTS
//   clk          in   1            oversampling clock (prescale cycles per bit)
//   reset        in   1            synchronous, active-high reset
//   prescale     in   6            cycles per bit; supported values 8, 16, 32
//   P_DATA       in   DATA_WIDTH   payload word
//   data_valid   in   1            request to send P_DATA
//   PAR_EN       in   1            1 = insert a parity bit
//   PAR_TYP      in   1            0 = even parity, 1 = odd parity
//   TX_OUT       out  1            serial line, registered, idle high
//   busy         out  1            high while a frame is in flight, registered
// BEHAVIOUR
//   Reset (synchronous, active-high): state=IDLE, TX_OUT=1, busy=0, all counters=0.
//     Reset takes effect on the next clk edge, including mid-frame; the line returns high at once.
//   Accept: a request is accepted on an edge where state=IDLE, data_valid=1, busy=0 and prescale is
//     one of {8,16,32}.
//     - On that edge, P_DATA, PAR_EN, PAR_TYP and prescale are latched.
//     - Requests with unsupported prescale values are ignored; the block stays IDLE.
//     - Later changes on the inputs do not affect the frame in flight.
//     - data_valid asserted while busy=1 is ignored. Nothing is queued.
//   Latency: accept on edge N -> TX_OUT=0 and busy=1 are visible after edge N.
//   Bit timing: each bit holds TX_OUT for exactly P cycles, where P is the latched prescale.
//     - A bit-cycle counter runs 0..P-1.
//     - When the count reaches P-1, the FSM advances to the next bit.
//   FSM states:
//     - IDLE   -> START on accept.
//     - START  (TX_OUT=0) -> DATA after P cycles.
//     - DATA   (TX_OUT=data[bit_idx], bit_idx = 0..DATA_WIDTH-1).
//         After bit DATA_WIDTH-1 completes: go to PARITY if PAR_EN, otherwise go to STOP.
//     - PARITY (TX_OUT = ^data XOR PAR_TYP) -> STOP after P cycles.
//     - STOP   (TX_OUT=1) -> IDLE after P cycles; busy=0 on that same edge.
//   Frame length: (DATA_WIDTH + 2 + PAR_EN) * P cycles, measured from the first start-bit cycle
//     to the last stop-bit cycle.
//   Back-to-back frames: the earliest next accept is on the edge following busy falling.
//     - The line therefore sees at least one idle-high cycle beyond the stop bit.
//   Widths: bit_idx is clog2(DATA_WIDTH) bits; the bit-cycle counter is 6 bits and never wraps past P-1.
//   Glitch-free: TX_OUT is driven only from a flop. No combinational path exists from inputs to TX_OUT.
// STRUCTURE
//   Shared package uart_pkg:
//     - FSM state enum (IDLE, START, DATA, PARITY, STOP)
//     - PAR_EVEN / PAR_ODD constants
//     - supported prescale constants PRESCALE_8/16/32
//     - these are reused by the RX side
//   Sub-module uart_tx_bit_timer:
//     - inputs: clk, reset, clear, latched prescale
//     - outputs: bit_done pulse on count P-1
//     - the FSM, data shift/index logic and parity computation stay in this top module
// TESTING
//   1. prescale=16, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5:
//      TX_OUT = 0,1,0,1,0,0,1,0,1,(parity 0),1, each bit held 16 cycles; busy high for 176 cycles.
//   2. prescale=8, PAR_EN=0, P_DATA=0x3C: 10 bits x 8 cycles = 80 busy cycles; no parity slot;
//      stop bit immediately follows data bit 7.
//   3. prescale=32, PAR_EN=1, PAR_TYP=1, P_DATA=0x00: parity bit = 1, held 32 cycles;
//      frame = 352 cycles.
//   4. data_valid held high continuously with P_DATA changed mid-frame:
//      - the first frame carries the original word;
//      - the second frame starts one cycle after busy falls, with at least one idle-high cycle between frames.
//   5. reset asserted during DATA bit 3: after the next edge, TX_OUT=1, busy=0 and state=IDLE;
//      a fresh request then sends a complete, correct frame.
//   6. prescale=12 with data_valid=1: no accept; busy stays 0 and TX_OUT stays 1 for 100 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity selectors and the supported
// oversampling ratios. Used by both the TX and RX data paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    function automatic logic prescale_supported(input logic [5:0] prescale);
        return (prescale == PRESCALE_8) || (prescale == PRESCALE_16) ||
               (prescale == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Counts oversampling cycles within one UART bit and pulses bit_done on the
// last cycle (count == prescale-1). The counter is held at zero while clear is high.
module uart_tx_bit_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [5:0] prescale,
    output logic       bit_done
);

    logic [5:0] count;
    logic       last_cycle;

    assign last_cycle = (count == prescale - 6'd1);
    assign bit_done   = last_cycle && !clear;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, regardless of the order the always_ff blocks are evaluated.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (last_cycle) begin
            count <= '0;
        end else begin
            count <= count + 6'd1;
        end
    end

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// UART transmitter: serializes one latched word into start, data (LSB first),
// optional parity and stop bits, each held for the latched prescale cycles.
module uart_tx_frame_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            prescale,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  data_valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    uart_state_t           state, state_n;
    logic [IDX_W-1:0]      bit_idx, bit_idx_n;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q, par_typ_q;
    logic [5:0]            prescale_q;
    logic                  accept, bit_done, tx_n;

    assign accept = (state == IDLE) && data_valid && !busy && prescale_supported(prescale);

    uart_tx_bit_timer u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == IDLE),
        .prescale (prescale_q),
        .bit_done (bit_done)
    );

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        unique case (state)
            IDLE:   if (accept) state_n = START;
            START:  if (bit_done) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end
            DATA:   if (bit_done) begin
                        if (bit_idx == LAST_IDX) state_n = par_en_q ? PARITY : STOP;
                        else                     bit_idx_n = bit_idx + IDX_W'(1);
                    end
            PARITY: if (bit_done) state_n = STOP;
            STOP:   if (bit_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Line level is decoded from the next state so TX_OUT comes straight off a flop.
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = data_q[bit_idx_n];
            PARITY:  tx_n = (^data_q) ^ (par_typ_q == PAR_ODD);
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_idx    <= '0;
            TX_OUT     <= 1'b1;
            busy       <= 1'b0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            prescale_q <= '0;
        end else begin
            state   <= state_n;
            bit_idx <= bit_idx_n;
            TX_OUT  <= tx_n;
            busy    <= (state_n != IDLE);
            if (accept) begin
                data_q     <= P_DATA;
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
                prescale_q <= prescale;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Scoreboard bench for the UART TX serializer: stimulus queues hand-computed
// frames, a negedge monitor captures each busy window and compares it bit by bit.
module tb_uart_tx_frame_serializer;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] prescale;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       busy;

    always #5 clk = ~clk;

    uart_tx_frame_serializer #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .prescale   (prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    typedef struct {
        string       name;
        logic [10:0] bits;         // line levels in transmit order, bit 0 first
        int          nbits;
        int          p;
        int          busy_cycles;
    } frame_t;

    frame_t sb[$];
    int     n_checks    = 0;
    int     n_fail      = 0;
    int     frames_seen = 0;

    logic   mon_in_frame = 1'b0;
    logic   mon_aborted  = 1'b0;
    logic   mon_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic push_exp(input string name, input logic [10:0] bits, input int nbits,
                            input int p, input int busy_cycles);
        frame_t f;
        f.name        = name;
        f.bits        = bits;
        f.nbits       = nbits;
        f.p           = p;
        f.busy_cycles = busy_cycles;
        sb.push_back(f);
    endtask

    task automatic compare_frame();
        frame_t f;
        int     match;
        if (sb.size() == 0) begin
            check("unexpected_frame", 1, 0);
            return;
        end
        f = sb.pop_front();
        frames_seen++;
        check({f.name, "_busy_cycles"}, mon_q.size(), f.busy_cycles);
        for (int k = 0; k < f.nbits; k++) begin
            match = 0;
            for (int j = 0; j < f.p; j++) begin
                if ((k * f.p + j) < mon_q.size() && mon_q[k * f.p + j] === f.bits[k]) match++;
            end
            check($sformatf("%s_bit%0d_cycles", f.name, k), match, f.p);
        end
    endtask

    // Monitor: one sample per cycle while busy; a reset inside a frame discards it.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_in_frame) begin
                if (reset === 1'b1) mon_aborted = 1'b1;
                if (busy === 1'b1) begin
                    mon_q.push_back(TX_OUT);
                end else begin
                    if (!mon_aborted) compare_frame();
                    mon_in_frame = 1'b0;
                    mon_q.delete();
                end
            end else if (busy === 1'b1 && reset !== 1'b1) begin
                mon_in_frame = 1'b1;
                mon_aborted  = 1'b0;
                mon_q.push_back(TX_OUT);
            end
        end
    end

    task automatic wait_busy(input logic level, input int limit, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== level && n < limit);
        check(name, busy, level);
    endtask

    // Issue one request, then scramble every input once it is accepted.
    task automatic send(input logic [7:0] data, input logic pe, input logic pt, input logic [5:0] presc,
                        input string name);
        @(posedge clk);
        #1;
        P_DATA     = data;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        prescale   = presc;
        data_valid = 1'b1;
        wait_busy(1'b1, 4, {name, "_accept"});
        data_valid = 1'b0;
        P_DATA     = ~data;
        PAR_EN     = ~pe;
        PAR_TYP    = ~pt;
        prescale   = (presc == PRESCALE_32) ? PRESCALE_8 : PRESCALE_32;
        wait_busy(1'b0, 400, {name, "_end"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int idle_ok;
        int bad;

        reset      = 1'b1;
        data_valid = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = PRESCALE_16;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_out", TX_OUT, 1);
        check("reset_busy", busy, 0);
        check("reset_state", dut.state, IDLE);
        reset = 1'b0;

        // 0xA5 even parity: 0 | 1,0,1,0,0,1,0,1 | 0 | 1
        push_exp("t1_a5_p16_even", {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 16, 176);
        send(8'hA5, 1'b1, PAR_EVEN, PRESCALE_16, "t1");

        // 0x3C no parity: stop directly after data bit 7
        push_exp("t2_3c_p8_nopar", {1'b0, 1'b1, 8'h3C, 1'b0}, 10, 8, 80);
        send(8'h3C, 1'b0, PAR_EVEN, PRESCALE_8, "t2");

        // 0x00 odd parity: parity bit 1
        push_exp("t3_00_p32_odd", {1'b1, 1'b1, 8'h00, 1'b0}, 11, 32, 352);
        send(8'h00, 1'b1, PAR_ODD, PRESCALE_32, "t3");

        // data_valid held high; P_DATA changes mid-frame
        push_exp("t4_first_5a", {1'b0, 1'b1, 8'h5A, 1'b0}, 10, 8, 80);
        push_exp("t4_second_c3", {1'b0, 1'b1, 8'hC3, 1'b0}, 10, 8, 80);
        @(posedge clk);
        #1;
        P_DATA     = 8'h5A;
        PAR_EN     = 1'b0;
        prescale   = PRESCALE_8;
        data_valid = 1'b1;
        wait_busy(1'b1, 4, "t4_accept1");
        repeat (20) @(negedge clk);
        P_DATA = 8'hC3;
        wait_busy(1'b0, 200, "t4_end1");
        gap     = 1;
        idle_ok = (TX_OUT === 1'b1) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy === 1'b1) break;
            gap++;
            if (TX_OUT !== 1'b1) idle_ok = 0;
        end
        check("t4_idle_gap_cycles", gap, 1);
        check("t4_idle_gap_line_high", idle_ok, 1);
        data_valid = 1'b0;
        wait_busy(1'b0, 200, "t4_end2");

        // reset during data bit 3 (frame cycles 32..39 at prescale 8)
        @(posedge clk);
        #1;
        P_DATA     = 8'hF7;
        PAR_EN     = 1'b0;
        prescale   = PRESCALE_8;
        data_valid = 1'b1;
        wait_busy(1'b1, 4, "t5_accept");
        data_valid = 1'b0;
        repeat (35) @(negedge clk);
        check("t5_pre_reset_bit3", TX_OUT, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_reset_tx_out", TX_OUT, 1);
        check("t5_reset_busy", busy, 0);
        check("t5_reset_state", dut.state, IDLE);
        reset = 1'b0;
        // 0x96 popcount 4 -> even parity 0
        push_exp("t5_fresh_96", {1'b1, 1'b0, 8'h96, 1'b0}, 11, 16, 176);
        send(8'h96, 1'b1, PAR_EVEN, PRESCALE_16, "t5_fresh");

        // unsupported prescale: never accepted
        @(posedge clk);
        #1;
        P_DATA     = 8'h55;
        prescale   = 6'd12;
        data_valid = 1'b1;
        bad        = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy !== 1'b0 || TX_OUT !== 1'b1) bad++;
        end
        check("t6_bad_prescale_active_cycles", bad, 0);
        data_valid = 1'b0;

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("frames_checked", frames_seen, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
